// File: rtl/icb_sram_slave_pkg.sv
// Shared ICB bus widths, response-FSM state type and window-decode helper.
package icb_sram_slave_pkg;

    localparam int unsigned ICB_ADDR_W = 32;
    localparam int unsigned ICB_DATA_W = 32;
    localparam int unsigned ICB_MASK_W = 4;

    // Response channel state: nothing pending, or one response being offered.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RSP  = 1'b1
    } icb_state_e;

    // A byte address hits the window when every bit above the word index
    // matches the base address; the low two byte-offset bits are ignored.
    function automatic logic addr_hit(
        input logic [ICB_ADDR_W-1:0] addr,
        input logic [ICB_ADDR_W-1:0] base,
        input int unsigned           aw
    );
        return (addr >> (aw + 2)) == (base >> (aw + 2));
    endfunction

endpackage

// File: rtl/icb_sram_slave_if.sv
// ICB command/response channel bundle between one master and one slave.
interface icb_sram_slave_if;
    import icb_sram_slave_pkg::*;

    logic                  icb_cmd_valid;
    logic                  icb_cmd_ready;
    logic [ICB_ADDR_W-1:0] icb_cmd_addr;
    logic                  icb_cmd_read;
    logic [ICB_DATA_W-1:0] icb_cmd_wdata;
    logic [ICB_MASK_W-1:0] icb_cmd_wmask;
    logic                  icb_rsp_valid;
    logic                  icb_rsp_ready;
    logic                  icb_rsp_err;
    logic [ICB_DATA_W-1:0] icb_rsp_rdata;

    modport master (
        output icb_cmd_valid,
        output icb_cmd_addr,
        output icb_cmd_read,
        output icb_cmd_wdata,
        output icb_cmd_wmask,
        output icb_rsp_ready,
        input  icb_cmd_ready,
        input  icb_rsp_valid,
        input  icb_rsp_err,
        input  icb_rsp_rdata
    );

    modport slave (
        input  icb_cmd_valid,
        input  icb_cmd_addr,
        input  icb_cmd_read,
        input  icb_cmd_wdata,
        input  icb_cmd_wmask,
        input  icb_rsp_ready,
        output icb_cmd_ready,
        output icb_rsp_valid,
        output icb_rsp_err,
        output icb_rsp_rdata
    );

endinterface

// File: rtl/icb_sram_slave_sram_sp.sv
// Single-port synchronous SRAM with per-byte write enables.
// Read data is registered and only changes on a read access, so it holds
// its value for as long as no new read is issued. The array has no reset.
module sram_sp #(
    parameter int unsigned AW = 10,
    parameter int unsigned MW = 4,
    parameter int unsigned DW = 8 * MW
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [MW-1:0] be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [0:(1 << AW)-1];
    logic [DW-1:0] rdata_q;

    // Byte-lane write, or registered read of the addressed word.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int unsigned i = 0; i < MW; i++) begin
                    if (be_i[i]) begin
                        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/icb_sram_slave.sv
// ICB slave fronting a single-port SRAM window at BASE_ADDR.
// One response per accepted command, delivered one cycle later; a new
// command can be accepted in the same cycle the current response retires.
module icb_sram_slave
    import icb_sram_slave_pkg::*;
#(
    parameter logic [ICB_ADDR_W-1:0] BASE_ADDR = 32'h1004_0000,
    parameter int unsigned           AW        = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    icb_sram_slave_if.slave    icb
);

    icb_state_e            state_q, state_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_rd_q, rsp_rd_d;

    logic                  cmd_ready;
    logic                  cmd_accept;
    logic                  rsp_hs;
    logic                  cmd_hit;
    logic [AW-1:0]         cmd_idx;
    logic                  sram_en;
    logic                  sram_we;
    logic [ICB_DATA_W-1:0] sram_rdata;

    assign cmd_ready  = (state_q == ST_IDLE) | icb.icb_rsp_ready;
    assign cmd_accept = icb.icb_cmd_valid & cmd_ready;
    assign rsp_hs     = (state_q == ST_RSP) & icb.icb_rsp_ready;
    assign cmd_hit    = addr_hit(icb.icb_cmd_addr, BASE_ADDR, AW);
    assign cmd_idx    = icb.icb_cmd_addr[AW+1:2];

    // rst_n gates the enable so a write presented on a reset edge is dropped.
    assign sram_en = cmd_accept & cmd_hit & rst_n;
    assign sram_we = ~icb.icb_cmd_read;

    sram_sp #(
        .AW (AW),
        .MW (ICB_MASK_W)
    ) u_sram (
        .clk_i   (clk),
        .en_i    (sram_en),
        .we_i    (sram_we),
        .be_i    (icb.icb_cmd_wmask),
        .addr_i  (cmd_idx),
        .wdata_i (icb.icb_cmd_wdata),
        .rdata_o (sram_rdata)
    );

    // Next response state plus the attributes of the response being built.
    always_comb begin
        state_d   = state_q;
        rsp_err_d = rsp_err_q;
        rsp_rd_d  = rsp_rd_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_accept) begin
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_hs) begin
                    state_d = cmd_accept ? ST_RSP : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (cmd_accept) begin
            rsp_err_d = ~cmd_hit;
            rsp_rd_d  = cmd_hit & icb.icb_cmd_read;
        end else if (rsp_hs) begin
            rsp_err_d = 1'b0;
            rsp_rd_d  = 1'b0;
        end
    end

    // Response state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rsp_err_q <= 1'b0;
            rsp_rd_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rsp_err_q <= rsp_err_d;
            rsp_rd_q  <= rsp_rd_d;
        end
    end

    // SRAM read register is the data holding stage; it only updates on an
    // accept, which cannot happen while a response is stalled.
    assign icb.icb_cmd_ready = cmd_ready;
    assign icb.icb_rsp_valid = (state_q == ST_RSP);
    assign icb.icb_rsp_err   = rsp_err_q;
    assign icb.icb_rsp_rdata = rsp_rd_q ? sram_rdata : '0;

endmodule

// File: tb/tb_icb_sram_slave.sv
// Randomized + directed bench for icb_sram_slave against a transaction-level
// model: a word array for memory contents and a queue of pending responses.
module tb_icb_sram_slave;

    localparam logic [31:0] BASE  = 32'h1004_0000;
    localparam int unsigned AW    = 10;
    localparam int unsigned WORDS = 1 << AW;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    icb_sram_slave_if bus();

    icb_sram_slave #(
        .BASE_ADDR (BASE),
        .AW        (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .icb   (bus)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        bit          known;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [31:0] ref_mem [WORDS];
    logic [3:0]  ref_kn  [WORDS];
    int          n_chk  = 0;
    int          n_fail = 0;
    bit          rst_seen = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input bit rd, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] m, input bit rr);
        bus.icb_cmd_valid = v;
        bus.icb_cmd_read  = rd;
        bus.icb_cmd_addr  = a;
        bus.icb_cmd_wdata = wd;
        bus.icb_cmd_wmask = m;
        bus.icb_rsp_ready = rr;
    endtask

    // One clock: check outputs mid-cycle, then advance the model across the edge.
    task automatic step();
        bit   exp_ready;
        bit   hit;
        int   idx;
        rsp_t r;
        @(negedge clk);
        exp_ready = (exp_q.size() == 0) || bus.icb_rsp_ready;
        check_eq("cmd_ready", 32'(bus.icb_cmd_ready), 32'(exp_ready));
        check_eq("rsp_valid", 32'(bus.icb_rsp_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check_eq("rsp_err", 32'(bus.icb_rsp_err), 32'(exp_q[0].err));
            if (exp_q[0].known) check_eq("rsp_rdata", bus.icb_rsp_rdata, exp_q[0].rdata);
        end else if (rst_seen) begin
            check_eq("rst_err", 32'(bus.icb_rsp_err), 32'd0);
            check_eq("rst_rdata", bus.icb_rsp_rdata, 32'd0);
        end
        rst_seen = 1'b0;

        if (!rst_n) begin
            exp_q.delete();
            rst_seen = 1'b1;
        end else begin
            if (exp_q.size() != 0 && bus.icb_rsp_ready) void'(exp_q.pop_front());
            if (bus.icb_cmd_valid && exp_ready) begin
                hit = (bus.icb_cmd_addr >> (AW + 2)) == (BASE >> (AW + 2));
                idx = int'((bus.icb_cmd_addr >> 2) % WORDS);
                if (!hit) begin
                    r = '{err: 1'b1, rdata: 32'd0, known: 1'b1};
                end else if (bus.icb_cmd_read) begin
                    r = '{err: 1'b0, rdata: ref_mem[idx], known: (ref_kn[idx] == 4'hF)};
                end else begin
                    for (int b = 0; b < 4; b++) begin
                        if (bus.icb_cmd_wmask[b]) begin
                            ref_mem[idx][8*b +: 8] = bus.icb_cmd_wdata[8*b +: 8];
                            ref_kn[idx][b] = 1'b1;
                        end
                    end
                    r = '{err: 1'b0, rdata: 32'd0, known: 1'b1};
                end
                exp_q.push_back(r);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < int'(WORDS); i++) ref_kn[i] = 4'h0;
        rst_n = 1'b0;
        drive(0, 0, 32'd0, 32'd0, 4'h0, 1);
        repeat (2) @(posedge clk);
        #1;
        step();
        rst_n = 1'b1;

        // Full-word write then read back, followed by a byte-lane merge.
        drive(1, 0, 32'h1004_0010, 32'hDEAD_BEEF, 4'hF, 1); step();
        drive(1, 1, 32'h1004_0010, 32'd0,         4'h0, 1); step();
        drive(1, 0, 32'h1004_0010, 32'h0000_AA00, 4'b0010, 1); step();
        drive(1, 1, 32'h1004_0012, 32'd0,         4'h0, 1); step();
        drive(0, 0, 32'd0, 32'd0, 4'h0, 1); step();
        check_eq("merge_model", ref_mem[4], 32'hDEAD_AAEF);

        // Empty mask writes nothing, misses never touch memory.
        drive(1, 0, 32'h1004_0000, 32'h1234_5678, 4'hF, 1); step();
        drive(1, 0, 32'h1004_0000, 32'hFFFF_FFFF, 4'h0, 1); step();
        drive(1, 1, 32'h1005_0000, 32'd0, 4'h0, 1); step();
        drive(1, 0, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 1); step();
        drive(1, 1, 32'h1004_0000, 32'd0, 4'h0, 1); step();
        drive(0, 0, 32'd0, 32'd0, 4'h0, 1); step();

        // Stall a read response for five cycles with a command waiting.
        drive(1, 1, 32'h1004_0010, 32'd0, 4'h0, 1); step();
        drive(1, 1, 32'h1004_0000, 32'd0, 4'h0, 0);
        repeat (5) step();
        drive(1, 1, 32'h1004_0000, 32'd0, 4'h0, 1); step();
        drive(0, 0, 32'd0, 32'd0, 4'h0, 1); step();

        // Sixteen back-to-back writes then sixteen reads.
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, BASE + 32'((32 + i) * 4), $urandom, 4'hF, 1); step();
        end
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, BASE + 32'((32 + i) * 4), 32'd0, 4'h0, 1); step();
        end
        drive(0, 0, 32'd0, 32'd0, 4'h0, 1); step();

        // Reset while a response is pending, with a write on the reset edge.
        drive(1, 1, 32'h1004_0010, 32'd0, 4'h0, 0); step();
        rst_n = 1'b0;
        drive(1, 0, 32'h1004_0010, 32'h5555_5555, 4'hF, 0); step();
        rst_n = 1'b1;
        drive(1, 1, 32'h1004_0010, 32'd0, 4'h0, 1); step();
        drive(0, 0, 32'd0, 32'd0, 4'h0, 1); step();

        // Randomized traffic over a small set of words plus misses and resets.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            if ($urandom_range(99) < 85) a = BASE + 32'($urandom_range(31) * 4) + 32'($urandom_range(3));
            else                         a = $urandom;
            rst_n = ($urandom_range(199) != 0);
            drive($urandom_range(99) < 75, $urandom_range(1) == 1, a, $urandom,
                  4'($urandom_range(15)), $urandom_range(99) < 75);
            step();
        end
        rst_n = 1'b1;
        drive(0, 0, 32'd0, 32'd0, 4'h0, 1);
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/icb_sram_slave.md
ICB_SRAM_SLAVE -- requirements
Module: icb_sram_slave

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1004_0000, byte base address of the window; aligned to window size.
REQ-002 Parameter AW, default 10, word-address width; window = 2^AW 32-bit words (4 KiB default).
REQ-003 clk  input  1  single clock, all logic rising-edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 icb_cmd_valid  input  1  command valid from ICB master.
REQ-006 icb_cmd_ready  output  1  command accepted when valid&ready.
REQ-007 icb_cmd_addr  input  32  byte address.
REQ-008 icb_cmd_read  input  1  1=read, 0=write.
REQ-009 icb_cmd_wdata  input  32  write data.
REQ-010 icb_cmd_wmask  input  4  byte enables, bit i enables wdata[8i+7:8i].
REQ-011 icb_rsp_valid  output  1  response valid.
REQ-012 icb_rsp_ready  input  1  master accepts response.
REQ-013 icb_rsp_err  output  1  error flag for current response.
REQ-014 icb_rsp_rdata  output  32  read data; 0 for writes and errors.

Function
REQ-015 Exactly one response per accepted command, in command order; at most one response outstanding.
REQ-016 icb_cmd_ready = !icb_rsp_valid | icb_rsp_ready (combinational); no dependency on icb_cmd_valid.
REQ-017 States: IDLE (rsp_valid=0) and RSP (rsp_valid=1); IDLE->RSP on cmd accept; RSP->IDLE on rsp handshake without new accept; RSP->RSP on rsp handshake with simultaneous cmd accept (back-to-back, one command per cycle sustained).
REQ-018 Latency: response valid exactly one cycle after command handshake.
REQ-019 Hit = icb_cmd_addr[31:AW+2] equals BASE_ADDR[31:AW+2]; word index = icb_cmd_addr[AW+1:2]; addr[1:0] ignored.
REQ-020 Write hit: on accept cycle, each byte lane with wmask bit set updated; other lanes unchanged; wmask=0 writes nothing but still responds err=0.
REQ-021 Read hit: rdata = memory word at index, captured at accept edge, held stable while rsp_valid && !rsp_ready.
REQ-022 Miss (read or write): no memory access, response err=1, rdata=0.
REQ-023 Read after write to same address in consecutive accepted commands returns the newly written data.
REQ-024 rsp_err and rsp_rdata SHALL not change while rsp_valid=1 and rsp_ready=0.
REQ-025 Memory contents not initialised by reset; reads of unwritten words return undefined data, err=0.

Reset
REQ-026 While rst_n=0 at clk edge: rsp_valid=0, rsp_err=0, rsp_rdata=0, state IDLE; cmd_ready therefore 1 after reset.
REQ-027 Reset mid-response drops the pending response; a write accepted on the same edge as reset asserted SHALL not modify memory.

Structure
REQ-028 Shared package holds ICB width constants (ADDR 32, DATA 32, MASK 4) and state encoding IDLE/RSP.
REQ-029 One sub-module: sram_sp (single-port, synchronous read, byte-write-enable, AW x 32), no reset on array.

Verification
REQ-030 Write 0xDEADBEEF mask 4'hF to 0x1004_0010, read 0x1004_0010 -> rsp err=0, rdata=0xDEADBEEF, one cycle after each accept.
REQ-031 Write 0x0000_AA00 mask 4'b0010 to same word -> subsequent read returns 0xDEADAAEF.
REQ-032 Read 0x1005_0000 (miss) -> err=1, rdata=0; write miss to 0x0000_0000 -> err=1, memory at index 0 unchanged.
REQ-033 Hold rsp_ready=0 for 5 cycles after read response -> cmd_ready=0, rsp_valid/rdata stable all 5 cycles; release -> next command accepted same cycle.
REQ-034 Stream 16 back-to-back writes then 16 reads with rsp_ready=1 -> 1 transaction/cycle, data in order, no bubbles.
REQ-035 Assert rst_n=0 while rsp_valid=1 -> next cycle rsp_valid=0, cmd_ready=1, prior memory contents retained.
